// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_div(input op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(input op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input op_t op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_signed_b(input op_t op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Operand/result handshake bundle between the execute stage and the multiply/divide unit.
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic             kill;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output kill, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  kill, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration on the 2*WIDTH accumulator: add-then-shift-right for multiply,
// shift-left-then-trial-subtract (restoring) for divide.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rext;
  logic [WIDTH-1:0] rem_sub;
  logic             borrow;

  always_comb begin
    acc_out = acc_in;
    sum     = '0;
    rext    = '0;
    rem_sub = '0;
    borrow  = 1'b0;
    if (is_div) begin
      // the shifted partial remainder needs one extra bit before the compare
      rext    = acc_in[2*WIDTH-1:WIDTH-1];
      borrow  = rext < {1'b0, operand};
      rem_sub = rext[WIDTH-1:0] - operand;
      if (borrow) begin
        acc_out = {rext[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end else begin
        acc_out = {rem_sub, acc_in[WIDTH-2:0], 1'b1};
      end
    end else begin
      sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: unsigned one-bit-per-cycle core with sign fix-up.
// Optional macro MDU_EARLY_OUT_EN: div-by-zero, signed overflow and zero multiply skip BUSY.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic       clk,
  input logic       rst,
  mdu_iter_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state, state_nxt;
  op_t                  op_q;
  logic [WIDTH-1:0]     a_q, b_q, opnd_q, spec_q, result_q;
  logic [2*WIDTH-1:0]   acc, acc_nxt, prod;
  logic [CNT_W-1:0]     cnt;
  logic                 neg_q, special_q;

  logic                 neg_a, neg_b, div_zero, ovf, mul_zero, special_c, early_c, neg_c;
  logic [WIDTH-1:0]     abs_a, abs_b, spec_c, fixed_res, final_res;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div(op_q)),
    .acc_in  (acc),
    .operand (opnd_q),
    .acc_out (acc_nxt)
  );

  // operand decode used during PREP: magnitudes, result sign and forced special results
  always_comb begin
    neg_a    = is_signed_a(op_q) && a_q[WIDTH-1];
    neg_b    = is_signed_b(op_q) && b_q[WIDTH-1];
    abs_a    = neg_a ? -a_q : a_q;
    abs_b    = neg_b ? -b_q : b_q;
    neg_c    = is_rem(op_q) ? neg_a : (neg_a ^ neg_b);
    div_zero = is_div(op_q) && (b_q == '0);
    ovf      = is_div(op_q) && is_signed_b(op_q) && (a_q == MIN_VAL) && (b_q == '1);
    mul_zero = !is_div(op_q) && ((a_q == '0) || (b_q == '0));
    special_c = div_zero || ovf || mul_zero;
    spec_c   = '0;
    if (div_zero) begin
      spec_c = is_rem(op_q) ? a_q : '1;
    end else if (ovf) begin
      spec_c = is_rem(op_q) ? '0 : MIN_VAL;
    end
`ifdef MDU_EARLY_OUT_EN
    early_c = special_c;
`else
    early_c = 1'b0;
`endif
  end

  always_comb begin
    prod      = neg_q ? -acc_nxt : acc_nxt;
    fixed_res = '0;
    if (!is_div(op_q)) begin
      fixed_res = (op_q == MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end else if (is_rem(op_q)) begin
      fixed_res = neg_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    end else begin
      fixed_res = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    end
    final_res = special_q ? spec_q : fixed_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // kill overrides every transition, including an acceptance in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = PREP;
      PREP: state_nxt = early_c ? DONE : BUSY;
      BUSY: if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= MUL;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      spec_q    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else if (bus.kill) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q <= op_t'(bus.op);
            a_q  <= bus.a;
            b_q  <= bus.b;
          end
        end
        PREP: begin
          acc       <= is_div(op_q) ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          opnd_q    <= is_div(op_q) ? abs_b : abs_a;
          neg_q     <= neg_c;
          special_q <= special_c;
          spec_q    <= spec_c;
          cnt       <= CNT_W'(WIDTH);
          if (early_c) result_q <= spec_c;
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) result_q <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized and directed self-checking bench for mdu_iter at WIDTH=32 against an arithmetic model.
module tb_mdu_iter;

  localparam int W = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failures = 0;
  logic [31:0] lastResult = '0;

  mdu_iter_if #(.WIDTH(W)) bus();

  mdu_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == MINV && b == '1) return MINV;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == '1) return '0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    if (op[2] && b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == MINV && b == '1) return 2;
    if (!op[2] && (a == 0 || b == 0)) return 2;
`endif
    return W + 2;
  endfunction

  // drives one request and returns just after the accepting edge
  task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int holdCycles);
    int lat = 1;
    logic [31:0] exp;
    exp = model(op, a, b);
    bus.out_ready = 1'b0;
    startOp(op, a, b);
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) begin
      checkOutput({tag, " timeout"}, 32'(bus.out_valid), 32'd1);
      return;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLatency(op, a, b)));
    checkOutput({tag, " result"}, bus.result, exp);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, " hold"}, {bus.result[29:0], bus.out_valid, bus.in_ready},
                  {exp[29:0], 1'b1, 1'b0});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, " release"}, {30'b0, bus.out_valid, bus.in_ready}, 32'b01);
    lastResult = exp;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          sel;
    bus.kill = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset state", {bus.result[29:0], bus.out_valid, bus.in_ready}, 32'b01);
    rst = 1'b0;

    applyStimulus("mul neg",     3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    applyStimulus("mulh min",    3'd1, MINV, MINV, 0);
    applyStimulus("mulhu max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus("mulhsu",      3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    applyStimulus("div neg",     3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus("rem neg",     3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus("divu",        3'd5, 32'd100, 32'd7, 0);
    applyStimulus("remu",        3'd7, 32'd100, 32'd7, 0);
    applyStimulus("divu by0",    3'd5, 32'd5, 32'd0, 0);
    applyStimulus("rem by0",     3'd6, 32'd5, 32'd0, 0);
    applyStimulus("div ovf",     3'd4, MINV, 32'hFFFF_FFFF, 0);
    applyStimulus("rem ovf",     3'd6, MINV, 32'hFFFF_FFFF, 0);
    applyStimulus("mul zero",    3'd0, 32'd0, 32'h1234_5678, 0);
    applyStimulus("backpressure", 3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5);

    // kill in the tenth BUSY cycle
    startOp(3'd5, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    checkOutput("kill idle", {30'b0, bus.out_valid, bus.in_ready}, 32'b01);
    checkOutput("kill result kept", bus.result, lastResult);
    begin
      int sawValid = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (bus.out_valid) sawValid++;
      end
      checkOutput("kill no valid", 32'(sawValid), 32'd0);
    end
    applyStimulus("after kill", 3'd5, 32'd9, 32'd3, 0);

    // kill coincident with acceptance drops the request
    bus.in_valid = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3; bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.kill = 1'b0;
    checkOutput("kill at accept", {30'b0, bus.out_valid, bus.in_ready}, 32'b01);

    // reset in the middle of BUSY
    startOp(3'd0, 32'h0001_0001, 32'h0000_0003);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid reset", {bus.result[29:0], bus.out_valid, bus.in_ready}, 32'b01);
    checkOutput("mid reset result", bus.result, 32'd0);
    applyStimulus("after reset", 3'd7, 32'd17, 32'd5, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = MINV; rb = '1; end
      else if (sel == 2) ra = '0;
      else if (sel == 3) rb = 32'($urandom_range(1, 15));
      applyStimulus($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
